// File: rtl/bp_pkg.sv
// Shared definitions for the branch-resolution controller and the predictor benches:
// record layout, controller state encoding and the mispredict compare.
package bp_pkg;

  localparam int GHR_W_DEFAULT = 5;
  localparam int PC_W          = 32;

  // Per-instruction prediction fields. The GHR snapshot is kept outside this struct
  // so its width can follow the GHR_W parameter of the instantiating module.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } rec_base_t;

  localparam int REC_BASE_W = $bits(rec_base_t);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // A branch mispredicts on a wrong direction, or on a taken branch whose BTB target
  // was stale. A jump is always taken, so a not-taken prediction or a wrong target mispredicts.
  function automatic logic is_mispredict(
    input logic            is_branch,
    input logic            pred_taken,
    input logic [PC_W-1:0] pred_target,
    input logic            taken,
    input logic [PC_W-1:0] target
  );
    if (is_branch)
      return (taken != pred_taken) || (taken && (target != pred_target));
    else
      return !pred_taken || (target != pred_target);
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Generic DEPTH-entry circular record FIFO with push, pop, clear and occupancy.
// A push into a full FIFO is legal when a pop happens in the same cycle.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wdata;
  end

  assign rdata     = mem[head];
  assign occupancy = count;

endmodule

// File: rtl/branch_resolution_ctrl.sv
// Tracks in-flight control instructions, resolves them against their gshare prediction,
// drives flush/redirect/history recovery and sequences the predictor training write.
module branch_resolution_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int GHR_W        = GHR_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic                     push_pred_taken,
  input  logic [31:0]              push_pred_target,
  input  logic [GHR_W-1:0]         push_ghr,
  output logic                     push_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_is_branch,
  input  logic                     resolve_taken,
  input  logic [31:0]              resolve_target,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic                     ghr_restore_valid,
  output logic [GHR_W-1:0]         ghr_restore,
  output logic                     upd_valid,
  output logic                     upd_is_branch,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  output logic [31:0]              upd_target,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     upd_mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     resolve_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int REC_W = REC_BASE_W + GHR_W;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  rec_base_t        push_base, head_base;
  logic [GHR_W-1:0] head_ghr;
  logic [REC_W-1:0] fifo_rdata;

  logic in_run, resolve_act, has_head, do_resolve, mispredict, push_acc;

  assign in_run      = (state == ST_RUN);
  assign resolve_act = in_run && resolve_valid;
  assign has_head    = (occupancy != '0);
  assign do_resolve  = resolve_act && has_head;
  assign {head_base, head_ghr} = fifo_rdata;

  assign mispredict = do_resolve &&
                      is_mispredict(resolve_is_branch, head_base.pred_taken,
                                    head_base.pred_target, resolve_taken, resolve_target);

  // The resolving pop frees a slot in the same cycle, so a full queue can still accept.
  assign push_ready = in_run && ((occupancy < OCC_W'(DEPTH)) || resolve_valid);
  // A push alongside a mispredict is wrong-path and must not survive the clear.
  assign push_acc   = push_valid && push_ready && !mispredict;

  assign push_base.pc          = push_pc;
  assign push_base.pred_taken  = push_pred_taken;
  assign push_base.pred_target = push_pred_target;

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_acc),
    .pop       (do_resolve),
    .clear     (mispredict),
    .wdata     ({push_base, push_ghr}),
    .rdata     (fifo_rdata),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: next-state values are defaulted first so no path through the block infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_next = ST_FLUSH;
          cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Registered result of the resolve, visible the cycle after resolve_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush             <= 1'b0;
      redirect_pc       <= '0;
      ghr_restore_valid <= 1'b0;
      ghr_restore       <= '0;
      upd_valid         <= 1'b0;
      upd_is_branch     <= 1'b0;
      upd_pc            <= '0;
      upd_taken         <= 1'b0;
      upd_target        <= '0;
      upd_ghr           <= '0;
      upd_mispredict    <= 1'b0;
      resolve_err       <= 1'b0;
    end else begin
      flush             <= mispredict;
      ghr_restore_valid <= mispredict;
      upd_valid         <= do_resolve;
      if (resolve_act && !has_head) resolve_err <= 1'b1;
      if (do_resolve) begin
        upd_is_branch  <= resolve_is_branch;
        upd_pc         <= head_base.pc;
        upd_taken      <= resolve_taken;
        upd_target     <= resolve_target;
        upd_ghr        <= head_ghr;
        upd_mispredict <= mispredict;
      end
      if (mispredict) begin
        redirect_pc <= resolve_taken ? resolve_target : head_base.pc + 32'd4;
        // Jumps never shift the BHSR, so their snapshot is already the right history.
        ghr_restore <= resolve_is_branch ? {head_ghr[GHR_W-2:0], resolve_taken} : head_ghr;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolution_ctrl.sv
// Directed bench for branch_resolution_ctrl: mispredict/flush, correct predictions,
// full-queue concurrency and wrap, jumps, wrong-path discard, empty resolve, reset mid-flush.
module tb_branch_resolution_ctrl;

  localparam int DEPTH = 4;
  localparam int GHR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_valid;
  logic [31:0]       push_pc;
  logic              push_pred_taken;
  logic [31:0]       push_pred_target;
  logic [GHR_W-1:0]  push_ghr;
  logic              push_ready;
  logic              resolve_valid;
  logic              resolve_is_branch;
  logic              resolve_taken;
  logic [31:0]       resolve_target;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic              ghr_restore_valid;
  logic [GHR_W-1:0]  ghr_restore;
  logic              upd_valid;
  logic              upd_is_branch;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_mispredict;
  logic [2:0]        occupancy;
  logic              resolve_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  branch_resolution_ctrl #(.DEPTH(DEPTH), .GHR_W(GHR_W), .FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .push_valid        (push_valid),
    .push_pc           (push_pc),
    .push_pred_taken   (push_pred_taken),
    .push_pred_target  (push_pred_target),
    .push_ghr          (push_ghr),
    .push_ready        (push_ready),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_target    (resolve_target),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .ghr_restore_valid (ghr_restore_valid),
    .ghr_restore       (ghr_restore),
    .upd_valid         (upd_valid),
    .upd_is_branch     (upd_is_branch),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .upd_ghr           (upd_ghr),
    .upd_mispredict    (upd_mispredict),
    .occupancy         (occupancy),
    .resolve_err       (resolve_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                          input logic [GHR_W-1:0] g);
    push_valid       = 1'b1;
    push_pc          = pc;
    push_pred_taken  = pt;
    push_pred_target = ptgt;
    push_ghr         = g;
  endtask

  task automatic set_resolve(input logic br, input logic tk, input logic [31:0] tgt);
    resolve_valid     = 1'b1;
    resolve_is_branch = br;
    resolve_taken     = tk;
    resolve_target    = tgt;
  endtask

  task automatic idle();
    push_valid    = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0; push_ghr = '0;
    resolve_is_branch = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_push_ready", push_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_flush", flush, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_resolve_err", resolve_err, 0);

    // Branch predicted not-taken, resolves taken
    set_push(32'h100, 1'b0, 32'h0, 5'b00101); step(); idle();
    check("t1_occ_after_push", occupancy, 1);
    set_resolve(1'b1, 1'b1, 32'h140); step(); idle();
    check("t1_flush", flush, 1);
    check("t1_redirect", redirect_pc, 32'h140);
    check("t1_ghr_rv", ghr_restore_valid, 1);
    check("t1_ghr_restore", ghr_restore, 5'b01011);
    check("t1_upd_valid", upd_valid, 1);
    check("t1_upd_mispredict", upd_mispredict, 1);
    check("t1_upd_pc", upd_pc, 32'h100);
    check("t1_occ", occupancy, 0);
    check("t1_ready_f0", push_ready, 0);
    step();
    check("t1_flush_pulse", flush, 0);
    check("t1_ready_f1", push_ready, 0);
    set_push(32'hDEAD, 1'b0, 32'h0, 5'b0); step(); idle();
    check("t1_flush_push_ignored", occupancy, 0);
    check("t1_ready_back", push_ready, 1);

    // Correct taken prediction
    set_push(32'h200, 1'b1, 32'h180, 5'b00011); step(); idle();
    set_resolve(1'b1, 1'b1, 32'h180); step(); idle();
    check("t2_upd_valid", upd_valid, 1);
    check("t2_upd_mispredict", upd_mispredict, 0);
    check("t2_flush", flush, 0);
    check("t2_ghr_rv", ghr_restore_valid, 0);
    check("t2_upd_target", upd_target, 32'h180);
    check("t2_upd_ghr", upd_ghr, 5'b00011);
    step();
    check("t2_upd_pulse", upd_valid, 0);

    // Fill the queue, then push concurrently with a resolve; pointers wrap
    for (int i = 0; i < 4; i++) begin
      set_push(32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h1008 + 32'(i) * 32'h10, 5'(i));
      step();
    end
    idle();
    check("t3_occ_full", occupancy, 4);
    check("t3_ready_full", push_ready, 0);
    set_push(32'h1040, 1'b1, 32'h1048, 5'd4);
    set_resolve(1'b1, 1'b1, 32'h1008);
    #1 check("t3_ready_concurrent", push_ready, 1);
    step(); idle();
    check("t3_occ_stays", occupancy, 4);
    check("t3_pop0_pc", upd_pc, 32'h1000);
    check("t3_pop0_mp", upd_mispredict, 0);
    for (int i = 1; i < 5; i++) begin
      set_resolve(1'b1, 1'b1, 32'h1008 + 32'(i) * 32'h10); step(); idle();
      check($sformatf("t3_pop%0d_pc", i), upd_pc, 32'h1000 + 32'(i) * 32'h10);
      check($sformatf("t3_pop%0d_ghr", i), upd_ghr, i);
    end
    check("t3_occ_drained", occupancy, 0);

    // JAL predicted not-taken
    set_push(32'h300, 1'b0, 32'h0, 5'b10110); step(); idle();
    set_resolve(1'b0, 1'b1, 32'h400); step(); idle();
    check("t4_flush", flush, 1);
    check("t4_redirect", redirect_pc, 32'h400);
    check("t4_upd_is_branch", upd_is_branch, 0);
    check("t4_ghr_restore", ghr_restore, 5'b10110);
    check("t4_ghr_rv", ghr_restore_valid, 1);
    step(); step();

    // Head mispredicts not-taken with younger records and a concurrent push
    for (int i = 0; i < 3; i++) begin
      set_push(32'h500 + 32'(i) * 32'h10, 1'b1, 32'h540 + 32'(i) * 32'h10, 5'b00001);
      step();
    end
    idle();
    check("t5_occ3", occupancy, 3);
    set_push(32'h530, 1'b1, 32'h570, 5'b00001);
    set_resolve(1'b1, 1'b0, 32'h540);
    step(); idle();
    check("t5_flush", flush, 1);
    check("t5_redirect", redirect_pc, 32'h504);
    check("t5_ghr_restore", ghr_restore, 5'b00010);
    check("t5_occ_cleared", occupancy, 0);
    step(); step();
    check("t5_push_discarded", occupancy, 0);

    // Resolve with an empty queue
    set_resolve(1'b1, 1'b1, 32'h0); step(); idle();
    check("t6_err", resolve_err, 1);
    check("t6_no_upd", upd_valid, 0);
    check("t6_no_flush", flush, 0);
    step();
    check("t6_err_sticky", resolve_err, 1);

    // Reset asserted mid-FLUSH
    set_push(32'h600, 1'b0, 32'h0, 5'b11111); step(); idle();
    set_resolve(1'b1, 1'b1, 32'h700); step(); idle();
    check("t7_flush_before", flush, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t7_flush", flush, 0);
    check("t7_ghr_rv", ghr_restore_valid, 0);
    check("t7_upd_valid", upd_valid, 0);
    check("t7_redirect", redirect_pc, 0);
    check("t7_err_cleared", resolve_err, 0);
    check("t7_occ", occupancy, 0);
    check("t7_ready", push_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolution_ctrl.md
Name: branch_resolution_ctrl

Overview:
- Tracks every in-flight control instruction (branch, JAL, JALR) between decode and execute in the 5-stage core.
- At EX resolution it compares the actual outcome against the prediction made by the gshare predictor, and on mismatch raises flush and redirect.
- Sequences the one-per-resolution training write into the predictor: PHT counter, BHSR, BTB and tag.
- Supplies the corrected global history for recovery after a misprediction.

Parameters:
- DEPTH, 4, number of in-flight control-instruction records (power of 2, ≥2).
- GHR_W, 5, global history width; matches predictor BHSR width.
- FLUSH_CYCLES, 2, cycles after a mispredict during which pushes are discarded (wrong-path ID traffic).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- push_valid  in  1  ID has decoded a control instruction
- push_pc  in  32  its PC
- push_pred_taken  in  1  prediction made at fetch
- push_pred_target  in  32  predicted target
- push_ghr  in  GHR_W  BHSR snapshot at prediction time
- push_ready  out  1  record accepted; ID stalls when low
- resolve_valid  in  1  EX resolves the oldest control instruction
- resolve_is_branch  in  1  conditional branch (else JAL/JALR)
- resolve_taken  in  1  actual direction (1 for jumps)
- resolve_target  in  32  actual target
- flush  out  1  one-cycle pulse: kill IF/ID/EX wrong path
- redirect_pc  out  32  fetch PC when flush=1
- ghr_restore_valid  out  1  overwrite predictor BHSR
- ghr_restore  out  GHR_W  corrected history
- upd_valid  out  1  predictor training strobe
- upd_is_branch  out  1  update PHT/BHSR (else BTB only)
- upd_pc  out  32  PC to index/tag
- upd_taken  out  1  actual direction
- upd_target  out  32  actual target
- upd_ghr  out  GHR_W  snapshot for PHT index
- upd_mispredict  out  1  BTB/tag write enable for branches
- occupancy  out  $clog2(DEPTH)+1  live records
- resolve_err  out  1  sticky: resolve while empty

Behaviour:
- Reset: queue empty, occupancy=0, state=RUN. All outputs 0 except push_ready=1. resolve_err cleared.
- Queue: circular FIFO, head/tail wrap at DEPTH. Record = {pc, pred_taken, pred_target, ghr}.
- push_ready = (state==RUN) && (occupancy<DEPTH || resolve_valid) — pop frees a slot in the same cycle.
- Accepted push in the same cycle as a resolve: occupancy unchanged.
- Mispredict, computed on the head record:
  - branch: resolve_taken≠pred_taken, or (taken && target≠pred_target).
  - jump: !pred_taken || target≠pred_target.
- All outputs are registered and valid the cycle after resolve_valid (1-cycle latency).
- Every resolve: upd_valid=1 for one cycle with the head fields and actual outcome; upd_mispredict = mispredict.
- On mispredict:
  - flush=1 for one cycle.
  - redirect_pc = resolve_taken ? resolve_target : pc+4 (mod 2^32).
  - ghr_restore_valid=1. For a branch, ghr_restore = {ghr[GHR_W-2:0], resolve_taken}; for a jump, ghr_restore = ghr.
  - Queue cleared: all younger records are wrong-path.
  - An accepted push in the same cycle is discarded.
  - state→FLUSH.
- FLUSH: push_ready=0, pushes ignored, counter runs FLUSH_CYCLES then →RUN. resolve_valid is ignored in FLUSH.
- Correct prediction: no flush, no restore; the predictor's speculative BHSR is already correct.
- Resolve with occupancy=0: no update, no flush, resolve_err←1 (sticky until reset).
- Reset mid-FLUSH or with queue non-empty: everything discarded, pending pulses suppressed next cycle.

Decomposition:
- Shared package (bp_pkg):
  - GHR_W default.
  - Record struct/field widths.
  - State encoding constants RUN/FLUSH.
  - The mispredict-compare function, reused by the predictor test bench.
- One sub-module: bp_inflight_fifo. It is the generic DEPTH-entry record FIFO with push/pop/clear and occupancy. The controller FSM, compare logic and output registers stay in the top.

Test Plan:
- Push branch pc=0x100, pred_taken=0, ghr=5'b00101; resolve taken, target=0x140.
  - Next cycle: flush=1, redirect_pc=0x140, ghr_restore=5'b01011.
  - upd_valid=1, upd_mispredict=1, occupancy=0, then push_ready=0 for 2 cycles.
- Push branch pc=0x200, pred_taken=1, target=0x180; resolve taken, 0x180.
  - upd_valid=1, upd_mispredict=0, flush=0, ghr_restore_valid=0.
- Push 4 records; push_ready=0 at occupancy=4.
  - A 5th push concurrent with a resolve is accepted; occupancy stays 4.
  - Tail wraps, and the records pop in order with PCs intact.
- Push JAL pc=0x300, pred_taken=0; resolve target=0x400.
  - flush=1, redirect_pc=0x400, upd_is_branch=0, ghr_restore equals the snapshot.
- Three records queued; head resolves not-taken while pred_taken=1, with a concurrent push.
  - redirect_pc=head pc+4, queue empty, the concurrent push is discarded.
- Resolve with empty queue → resolve_err=1, no upd_valid/flush. Assert reset mid-FLUSH → all outputs at reset values next cycle.
